vga_timing_ctrl: RTL and testbench

//   VGA raster timing controller for the display pipeline. Scans a 640x480@60 frame
//   (25.2 MHz vga_clk), drives hsync/vsync, and requests pixels from the pixel

---
 rtl/vga_timing_pkg.sv | 50 +++++
 rtl/vga_axis_timing.sv | 60 ++++++
 rtl/vga_timing_ctrl.sv | 111 +++++++++++
 tb/tb_vga_timing_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : 640x480@60 raster defaults, coordinate/colour types and colour
//            constants shared by the timing controller and pixel generators.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 24;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0]   rgb_t;

  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_VALID = 640;
  localparam int H_FRONT = 16;

  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_VALID = 480;
  localparam int V_FRONT = 10;

  function automatic int axis_total(input int sync, input int back,
                                    input int valid, input int front);
    return sync + back + valid + front;
  endfunction

  localparam int H_TOTAL = axis_total(H_SYNC, H_BACK, H_VALID, H_FRONT);
  localparam int V_TOTAL = axis_total(V_SYNC, V_BACK, V_VALID, V_FRONT);

  // Coordinate value presented whenever no pixel is being requested
  localparam coord_t NO_REQ = 10'h3FF;

  localparam rgb_t BLACK   = 24'h000000;
  localparam rgb_t WHITE   = 24'hFFFFFF;
  localparam rgb_t RED     = 24'hFF0000;
  localparam rgb_t GREEN   = 24'h00FF00;
  localparam rgb_t BLUE    = 24'h0000FF;
  localparam rgb_t YELLOW  = 24'hFFFF00;
  localparam rgb_t CYAN    = 24'h00FFFF;
  localparam rgb_t MAGENTA = 24'hFF00FF;
  localparam rgb_t GREY    = 24'h808080;

endpackage

`default_nettype wire

// File: rtl/vga_axis_timing.sv
// ============================================================================
// Module   : vga_axis_timing
// Purpose  : One raster axis: wrap counter with enable, sync/active/request
//            window decode and request-coordinate offset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_timing
  import vga_timing_pkg::*;
#(
  parameter int SYNC  = 96,
  parameter int BACK  = 48,
  parameter int VALID = 640,
  parameter int FRONT = 16,
  parameter int LEAD  = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_en,
  output logic   o_first,
  output logic   o_wrap,
  output logic   o_sync,
  output logic   o_active,
  output logic   o_req,
  output coord_t o_coord
);

  localparam int     TOTAL    = axis_total(SYNC, BACK, VALID, FRONT);
  localparam coord_t C_LAST   = coord_t'(TOTAL - 1);
  localparam coord_t C_SYNC   = coord_t'(SYNC);
  localparam coord_t C_ACT_LO = coord_t'(SYNC + BACK);
  localparam coord_t C_ACT_HI = coord_t'(SYNC + BACK + VALID);
  localparam coord_t C_REQ_LO = coord_t'(SYNC + BACK - LEAD);
  localparam coord_t C_REQ_HI = coord_t'(SYNC + BACK + VALID - LEAD);

  coord_t r_cnt;
  logic   w_at_last;

  assign w_at_last = (r_cnt == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 10'd1;
    end
  end

  // Wrap is an event: last count while enabled, so it can chain the next axis
  assign o_wrap   = w_at_last && i_en;
  assign o_first  = (r_cnt == '0);
  assign o_sync   = (r_cnt < C_SYNC);
  assign o_active = (r_cnt >= C_ACT_LO) && (r_cnt < C_ACT_HI);
  assign o_req    = (r_cnt >= C_REQ_LO) && (r_cnt < C_REQ_HI);
  assign o_coord  = r_cnt - C_REQ_LO;

endmodule

`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
// ============================================================================
// Module   : vga_timing_ctrl
// Purpose  : VGA raster timing: sync generation, early pixel requests and
//            active-area blanking. Optional frame counter: VGA_FRAME_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
  parameter int H_BACK  = vga_timing_pkg::H_BACK,
  parameter int H_VALID = vga_timing_pkg::H_VALID,
  parameter int H_FRONT = vga_timing_pkg::H_FRONT,
  parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
  parameter int V_BACK  = vga_timing_pkg::V_BACK,
  parameter int V_VALID = vga_timing_pkg::V_VALID,
  parameter int V_FRONT = vga_timing_pkg::V_FRONT,
  parameter int PIX_LAT = 1
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [23:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_data_req,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [23:0] rgb,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        frame_start
);

  logic   w_h_first, w_h_wrap, w_h_sync, w_h_act, w_h_req;
  logic   w_v_first, w_v_wrap, w_v_sync, w_v_act, w_v_req;
  coord_t w_h_coord, w_v_coord;
  logic   w_req;

  // Horizontal requests lead the active window by the pixel-source latency
  vga_axis_timing #(
    .SYNC  (H_SYNC),
    .BACK  (H_BACK),
    .VALID (H_VALID),
    .FRONT (H_FRONT),
    .LEAD  (PIX_LAT)
  ) u_h_axis (
    .clk      (vga_clk),
    .rst      (sys_rst),
    .i_en     (1'b1),
    .o_first  (w_h_first),
    .o_wrap   (w_h_wrap),
    .o_sync   (w_h_sync),
    .o_active (w_h_act),
    .o_req    (w_h_req),
    .o_coord  (w_h_coord)
  );

  vga_axis_timing #(
    .SYNC  (V_SYNC),
    .BACK  (V_BACK),
    .VALID (V_VALID),
    .FRONT (V_FRONT),
    .LEAD  (0)
  ) u_v_axis (
    .clk      (vga_clk),
    .rst      (sys_rst),
    .i_en     (w_h_wrap),
    .o_first  (w_v_first),
    .o_wrap   (w_v_wrap),
    .o_sync   (w_v_sync),
    .o_active (w_v_act),
    .o_req    (w_v_req),
    .o_coord  (w_v_coord)
  );

  assign w_req        = w_h_req && w_v_req;

  assign hsync        = w_h_sync;
  assign vsync        = w_v_sync;
  assign frame_start  = w_h_first && w_v_first;
  assign rgb_valid    = w_h_act && w_v_act;
  assign pix_data_req = w_req;
  assign pix_x        = w_req ? w_h_coord : NO_REQ;
  assign pix_y        = w_req ? w_v_coord : NO_REQ;
  assign rgb          = rgb_valid ? pix_data : BLACK;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Counts completed frames; w_v_wrap fires on the last clock of a frame
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_frame_cnt <= '0;
    end else if (w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  logic w_unused_v_wrap;
  assign w_unused_v_wrap = w_v_wrap;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
// ============================================================================
// Module   : tb_vga_timing_ctrl
// Purpose  : Scoreboard bench: full-size DUT with directed raster points and a
//            reduced-geometry DUT checked every clock against a frame model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_ctrl;

  // Reduced geometry: H_TOTAL 13 (HA 5), V_TOTAL 7 (VA 3), frame 91 clocks
  localparam int S_HS = 3, S_HB = 2, S_HV = 6, S_HF = 2;
  localparam int S_VS = 1, S_VB = 2, S_VV = 3, S_VF = 1;
  localparam int S_LAT = 2;
  localparam int S_HT = 13, S_VT = 7, S_FT = 91;
  localparam int S_HA = 5, S_VA = 3;

  typedef struct {
    int          g;
    string       tag;
    logic        hs, vs, fs, rv, rq;
    logic [9:0]  px, py;
    logic [23:0] rgb;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b0, rst_s = 1'b0;
  logic [23:0] pd_d = '0, pd_s = '0, ps1 = '0;
  logic [9:0]  px_d, py_d, px_s, py_s;
  logic        rq_d, hs_d, vs_d, rv_d, fs_d, rq_s, hs_s, vs_s, rv_s, fs_s;
  logic [23:0] rgb_d, rgb_s;
  logic [15:0] fc_d, fc_s;

  vga_timing_ctrl u_dut_d (
    .vga_clk      (clk),
    .sys_rst      (rst_d),
    .pix_data     (pd_d),
    .pix_x        (px_d),
    .pix_y        (py_d),
    .pix_data_req (rq_d),
    .hsync        (hs_d),
    .vsync        (vs_d),
    .rgb_valid    (rv_d),
    .rgb          (rgb_d),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt    (fc_d),
`endif
    .frame_start  (fs_d)
  );

  vga_timing_ctrl #(
    .H_SYNC (S_HS), .H_BACK (S_HB), .H_VALID (S_HV), .H_FRONT (S_HF),
    .V_SYNC (S_VS), .V_BACK (S_VB), .V_VALID (S_VV), .V_FRONT (S_VF),
    .PIX_LAT(S_LAT)
  ) u_dut_s (
    .vga_clk      (clk),
    .sys_rst      (rst_s),
    .pix_data     (pd_s),
    .pix_x        (px_s),
    .pix_y        (py_s),
    .pix_data_req (rq_s),
    .hsync        (hs_s),
    .vsync        (vs_s),
    .rgb_valid    (rv_s),
    .rgb          (rgb_s),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt    (fc_s),
`endif
    .frame_start  (fs_s)
  );

`ifndef VGA_FRAME_CNT_EN
  assign fc_d = 16'h0;
  assign fc_s = 16'h0;
`endif

  // Pixel generators returning {pix_y,pix_x}: 1-clock and 2-clock latency
  always @(posedge clk) begin
    pd_d <= {4'h0, py_d, px_d};
    ps1  <= {4'h0, py_s, px_s};
    pd_s <= ps1;
  end

  exp_t q_d[$];
  exp_t q_s[$];
  int   g_d = 0, g_s = 0;
  int   n_checks = 0, n_pass = 0;
  logic done_d = 1'b0, done_s = 1'b0;

  function automatic exp_t dv(input int n, input string tag, input logic hs,
                              input logic vs, input logic fs, input logic rv,
                              input logic rq, input logic [9:0] px,
                              input logic [9:0] py, input logic [23:0] rgb);
    exp_t e;
    e.g = n; e.tag = tag; e.hs = hs; e.vs = vs; e.fs = fs; e.rv = rv; e.rq = rq;
    e.px = px; e.py = py; e.rgb = rgb; e.fc = 16'h0;
    return e;
  endfunction

  function automatic exp_t rst_rec(input string tag);
    return dv(0, tag, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 24'h0);
  endfunction

  // Expected outputs of the reduced DUT, n clocks after reset release
  function automatic exp_t smodel(input int n);
    exp_t e;
    int h, v;
    logic vwin;
    h = n % S_HT;
    v = (n / S_HT) % S_VT;
    vwin = (v >= S_VA) && (v < S_VA + S_VV);
    e.g   = 0;
    e.tag = $sformatf("s_scan_n%0d_h%0d_v%0d", n, h, v);
    e.hs  = (h < S_HS);
    e.vs  = (v < S_VS);
    e.fs  = (h == 0) && (v == 0);
    e.rv  = (h >= S_HA) && (h < S_HA + S_HV) && vwin;
    e.rq  = (h >= S_HA - S_LAT) && (h < S_HA + S_HV - S_LAT) && vwin;
    e.px  = e.rq ? 10'(h - (S_HA - S_LAT)) : 10'h3FF;
    e.py  = e.rq ? 10'(v - S_VA) : 10'h3FF;
    e.rgb = e.rv ? {4'h0, 10'(v - S_VA), 10'(h - S_HA)} : 24'h0;
`ifdef VGA_FRAME_CNT_EN
    e.fc  = 16'(n / S_FT);
`else
    e.fc  = 16'h0;
`endif
    return e;
  endfunction

  task automatic check(input exp_t e, input logic [64:0] act);
    logic [64:0] expv;
    expv = {e.hs, e.vs, e.fs, e.rv, e.rq, e.px, e.py, e.rgb, e.fc};
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s g=%0d actual{hs,vs,fs,rv,rq,px,py,rgb,fc}=%h required=%h",
                  e.tag, e.g, act, expv);
  endtask

  // Monitors: sample at negedge, pop every expectation due at this sample
  initial begin : mon_d
    exp_t e;
    forever begin
      @(negedge clk);
      g_d++;
      while (q_d.size() > 0 && q_d[0].g <= g_d) begin
        e = q_d.pop_front();
        if (e.g < g_d) begin
          n_checks++;
          $display("FAIL %s stale expectation g=%0d now=%0d", e.tag, e.g, g_d);
        end else begin
          check(e, {hs_d, vs_d, fs_d, rv_d, rq_d, px_d, py_d, rgb_d, fc_d});
        end
      end
    end
  end

  initial begin : mon_s
    exp_t e;
    forever begin
      @(negedge clk);
      g_s++;
      while (q_s.size() > 0 && q_s[0].g <= g_s) begin
        e = q_s.pop_front();
        if (e.g < g_s) begin
          n_checks++;
          $display("FAIL %s stale expectation g=%0d now=%0d", e.tag, e.g, g_s);
        end else begin
          check(e, {hs_s, vs_s, fs_s, rv_s, rq_s, px_s, py_s, rgb_s, fc_s});
        end
      end
    end
  end

  // Full-size DUT: hand-computed raster points (n = cnt_v*800 + cnt_h)
  initial begin : stim_d
    exp_t tbl[$];
    exp_t e;
    int   k;
    tbl.push_back(dv(0,     "d_h0_v0",     1, 1, 1, 0, 0, 10'h3FF, 10'h3FF, 24'h0));
    tbl.push_back(dv(95,    "d_h95_sync",  1, 1, 0, 0, 0, 10'h3FF, 10'h3FF, 24'h0));
    tbl.push_back(dv(96,    "d_h96_nosync",0, 1, 0, 0, 0, 10'h3FF, 10'h3FF, 24'h0));
    tbl.push_back(dv(799,   "d_h799",      0, 1, 0, 0, 0, 10'h3FF, 10'h3FF, 24'h0));
    tbl.push_back(dv(800,   "d_line1_h0",  1, 1, 0, 0, 0, 10'h3FF, 10'h3FF, 24'h0));
    tbl.push_back(dv(1599,  "d_v1_h799",   0, 1, 0, 0, 0, 10'h3FF, 10'h3FF, 24'h0));
    tbl.push_back(dv(1600,  "d_v2_h0",     1, 0, 0, 0, 0, 10'h3FF, 10'h3FF, 24'h0));
    tbl.push_back(dv(27343, "d_v34_h143",  0, 0, 0, 0, 0, 10'h3FF, 10'h3FF, 24'h0));
    tbl.push_back(dv(28142, "d_v35_h142",  0, 0, 0, 0, 0, 10'h3FF, 10'h3FF, 24'h0));
    tbl.push_back(dv(28143, "d_v35_h143",  0, 0, 0, 0, 1, 10'd0,   10'd0,   24'h0));
    tbl.push_back(dv(28144, "d_v35_h144",  0, 0, 0, 1, 1, 10'd1,   10'd0,   24'h0));
    tbl.push_back(dv(28145, "d_v35_h145",  0, 0, 0, 1, 1, 10'd2,   10'd0,   24'h000001));
    tbl.push_back(dv(28782, "d_v35_h782",  0, 0, 0, 1, 1, 10'd639, 10'd0,   24'h00027E));
    tbl.push_back(dv(28783, "d_v35_h783",  0, 0, 0, 1, 0, 10'h3FF, 10'h3FF, 24'h00027F));
    tbl.push_back(dv(28784, "d_v35_h784",  0, 0, 0, 0, 0, 10'h3FF, 10'h3FF, 24'h0));
    tbl.push_back(dv(29000, "d_v36_h200",  0, 0, 0, 1, 1, 10'd57,  10'd1,   24'h000438));

    #1 rst_d = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      e = rst_rec("d_in_reset"); e.g = g_d + 1; q_d.push_back(e);
    end
    @(posedge clk); #2;
    rst_d = 1'b0;
    k = 0;
    for (int n = 0; n <= 29000; n++) begin
      if (n > 0) begin
        @(posedge clk); #2;
      end
      if (k < tbl.size() && tbl[k].g == n) begin
        e = tbl[k]; e.g = g_d + 1; q_d.push_back(e);
        k++;
      end
    end
    done_d = 1'b1;
  end

  // Reduced DUT: 3+ frames, async reset mid-active-line, then 2+ frames
  initial begin : stim_s
    exp_t e;
    #1 rst_s = 1'b1;
    repeat (2) begin
      @(posedge clk); #2;
      e = rst_rec("s_in_reset"); e.g = g_s + 1; q_s.push_back(e);
    end
    @(posedge clk); #2;
    rst_s = 1'b0;
    for (int n = 0; n < 3 * S_FT + 60; n++) begin
      if (n > 0) begin
        @(posedge clk); #2;
      end
      e = smodel(n); e.g = g_s + 1; q_s.push_back(e);
    end
    // Next count would be cnt_h=8, cnt_v=4 (inside the active area)
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      rst_s = 1'b1;
      e = rst_rec($sformatf("s_mid_reset_%0d", i)); e.g = g_s + 1; q_s.push_back(e);
    end
    @(posedge clk); #2;
    rst_s = 1'b0;
    for (int n = 0; n < 2 * S_FT + 6; n++) begin
      if (n > 0) begin
        @(posedge clk); #2;
      end
      e = smodel(n); e.g = g_s + 1; q_s.push_back(e);
    end
    done_s = 1'b1;
  end

  initial begin : finish_blk
    wait (done_d && done_s);
    repeat (3) @(negedge clk);
    n_checks++;
    if (q_d.size() == 0 && q_s.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain actual=%0d/%0d left required=0/0",
                  q_d.size(), q_s.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "time limit reached");
  end

endmodule

`default_nettype wire
